// File: rtl/race_round_scheduler.sv
// race_round_scheduler: fetches targets, qualifies player answers,
// arbitrates A/B ties and paces the single-player opponent.
module race_round_scheduler #(
    parameter int WIN_SCORE     = 3,
    parameter int STABLE_CYC    = 4,
    parameter int OPP_DIV       = 9,
    parameter int OPP_LIMIT     = 80,
    parameter int REJECT_REPEAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode_2p,
    input  logic       abort,
    input  logic [7:0] Ain,
    input  logic [7:0] Bin,
    output logic       tgt_req,
    input  logic       tgt_valid,
    input  logic [7:0] tgt_in,
    output logic [7:0] target,
    output logic       point_a,
    output logic       point_b,
    output logic       opp_step,
    output logic [3:0] score_a,
    output logic [3:0] score_b,
    output logic [7:0] opp_steps,
    output logic [2:0] state,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int CW = (OPP_DIV > 1) ? $clog2(OPP_DIV) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC - 1);
    localparam logic [SW-1:0] STAB_ONE = SW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OPP_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    WIN_S    = 4'(WIN_SCORE);
    localparam logic [7:0]    OPP_LIM  = 8'(OPP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PLAY  = 3'd2,
        S_AWARD = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      target_q, target_d;
    logic            tgt_req_q, tgt_req_d;
    logic            point_a_q, point_a_d;
    logic            point_b_q, point_b_d;
    logic            opp_step_q, opp_step_d;
    logic [3:0]      score_a_q, score_a_d;
    logic [3:0]      score_b_q, score_b_d;
    logic [7:0]      opp_steps_q, opp_steps_d;
    logic [1:0]      winner_q, winner_d;
    logic            game_over_q, game_over_d;
    logic [SW-1:0]   stab_a_q, stab_a_d;
    logic [SW-1:0]   stab_b_q, stab_b_d;
    logic [CW-1:0]   opp_cnt_q, opp_cnt_d;
    logic            tie_prio_q, tie_prio_d;
    logic            mode_q, mode_d;
    logic            award_b_q, award_b_d;

    logic       match_a, match_b;
    logic       qual_a, qual_b;
    logic       pick_b;
    logic       opp_wrap;
    logic       refuse;
    logic [3:0] score_a_nx, score_b_nx;
    logic [7:0] opp_steps_nx;

    // B only competes in two-player mode
    assign match_a      = (Ain == target_q);
    assign match_b      = mode_q && (Bin == target_q);
    assign qual_a       = match_a && (stab_a_q == STAB_MAX);
    assign qual_b       = match_b && (stab_b_q == STAB_MAX);
    assign pick_b       = (qual_a && qual_b) ? tie_prio_q : qual_b;
    assign opp_wrap     = !mode_q && (opp_cnt_q == CNT_MAX);
    assign refuse       = (REJECT_REPEAT != 0) && (tgt_in == target_q);
    assign score_a_nx   = score_a_q + 4'd1;
    assign score_b_nx   = score_b_q + 4'd1;
    assign opp_steps_nx = opp_steps_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        tgt_req_d   = tgt_req_q;
        point_a_d   = 1'b0;
        point_b_d   = 1'b0;
        opp_step_d  = 1'b0;
        score_a_d   = score_a_q;
        score_b_d   = score_b_q;
        opp_steps_d = opp_steps_q;
        winner_d    = winner_q;
        game_over_d = game_over_q;
        stab_a_d    = stab_a_q;
        stab_b_d    = stab_b_q;
        opp_cnt_d   = opp_cnt_q;
        tie_prio_d  = tie_prio_q;
        mode_d      = mode_q;
        award_b_d   = award_b_q;

        if (abort) begin
            state_d     = S_IDLE;
            tgt_req_d   = 1'b0;
            game_over_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_FETCH;
                        tgt_req_d   = 1'b1;
                        mode_d      = mode_2p;
                        score_a_d   = 4'd0;
                        score_b_d   = 4'd0;
                        opp_steps_d = 8'd0;
                        winner_d    = 2'b00;
                        game_over_d = 1'b0;
                    end
                end
                S_FETCH: begin
                    tgt_req_d = 1'b1;
                    if (tgt_valid && !refuse) begin
                        target_d  = tgt_in;
                        tgt_req_d = 1'b0;
                        state_d   = S_PLAY;
                        stab_a_d  = '0;
                        stab_b_d  = '0;
                        opp_cnt_d = '0;
                    end
                end
                S_PLAY: begin
                    if (!match_a)
                        stab_a_d = '0;
                    else if (stab_a_q != STAB_MAX)
                        stab_a_d = stab_a_q + STAB_ONE;
                    if (!match_b)
                        stab_b_d = '0;
                    else if (stab_b_q != STAB_MAX)
                        stab_b_d = stab_b_q + STAB_ONE;
                    if (!mode_q)
                        opp_cnt_d = opp_wrap ? '0 : opp_cnt_q + CNT_ONE;
                    // a qualifying player beats an opponent wrap in the same cycle
                    if (qual_a || qual_b) begin
                        state_d   = S_AWARD;
                        award_b_d = pick_b;
                        point_a_d = !pick_b;
                        point_b_d = pick_b;
                        if (qual_a && qual_b)
                            tie_prio_d = !tie_prio_q;
                    end else if (opp_wrap) begin
                        opp_step_d  = 1'b1;
                        opp_steps_d = opp_steps_nx;
                        if (opp_steps_nx == OPP_LIM) begin
                            state_d     = S_DONE;
                            winner_d    = 2'b11;
                            game_over_d = 1'b1;
                        end
                    end
                end
                S_AWARD: begin
                    if (award_b_q) begin
                        score_b_d = score_b_nx;
                        if (score_b_nx == WIN_S) begin
                            state_d     = S_DONE;
                            winner_d    = 2'b10;
                            game_over_d = 1'b1;
                        end else begin
                            state_d   = S_FETCH;
                            tgt_req_d = 1'b1;
                        end
                    end else begin
                        score_a_d = score_a_nx;
                        if (score_a_nx == WIN_S) begin
                            state_d     = S_DONE;
                            winner_d    = 2'b01;
                            game_over_d = 1'b1;
                        end else begin
                            state_d   = S_FETCH;
                            tgt_req_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            target_q    <= 8'd0;
            tgt_req_q   <= 1'b0;
            point_a_q   <= 1'b0;
            point_b_q   <= 1'b0;
            opp_step_q  <= 1'b0;
            score_a_q   <= 4'd0;
            score_b_q   <= 4'd0;
            opp_steps_q <= 8'd0;
            winner_q    <= 2'b00;
            game_over_q <= 1'b0;
            stab_a_q    <= '0;
            stab_b_q    <= '0;
            opp_cnt_q   <= '0;
            tie_prio_q  <= 1'b0;
            mode_q      <= 1'b0;
            award_b_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            tgt_req_q   <= tgt_req_d;
            point_a_q   <= point_a_d;
            point_b_q   <= point_b_d;
            opp_step_q  <= opp_step_d;
            score_a_q   <= score_a_d;
            score_b_q   <= score_b_d;
            opp_steps_q <= opp_steps_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            stab_a_q    <= stab_a_d;
            stab_b_q    <= stab_b_d;
            opp_cnt_q   <= opp_cnt_d;
            tie_prio_q  <= tie_prio_d;
            mode_q      <= mode_d;
            award_b_q   <= award_b_d;
        end
    end

    assign state     = state_q;
    assign target    = target_q;
    assign tgt_req   = tgt_req_q;
    assign point_a   = point_a_q;
    assign point_b   = point_b_q;
    assign opp_step  = opp_step_q;
    assign score_a   = score_a_q;
    assign score_b   = score_b_q;
    assign opp_steps = opp_steps_q;
    assign winner    = winner_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_race_round_scheduler.sv
// Scoreboard bench for race_round_scheduler: pulses are predicted by the
// stimulus and popped/compared by an independent negedge monitor.
module tb_race_round_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode_2p = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] Ain = 8'd0;
    logic [7:0] Bin = 8'd0;
    logic       tgt_valid = 1'b0;
    logic [7:0] tgt_in = 8'd0;
    logic       tgt_req;
    logic [7:0] target;
    logic       point_a, point_b, opp_step;
    logic [3:0] score_a, score_b;
    logic [7:0] opp_steps;
    logic [2:0] state;
    logic       game_over;
    logic [1:0] winner;

    race_round_scheduler #(
        .WIN_SCORE(3), .STABLE_CYC(4), .OPP_DIV(2),
        .OPP_LIMIT(3), .REJECT_REPEAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_2p(mode_2p),
        .abort(abort), .Ain(Ain), .Bin(Bin), .tgt_req(tgt_req),
        .tgt_valid(tgt_valid), .tgt_in(tgt_in), .target(target),
        .point_a(point_a), .point_b(point_b), .opp_step(opp_step),
        .score_a(score_a), .score_b(score_b), .opp_steps(opp_steps),
        .state(state), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] PA = 3'b100, PB = 3'b010, PO = 3'b001;

    typedef struct packed {
        logic [2:0] pulses;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [7:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] p, input logic [3:0] sa,
                        input logic [3:0] sb, input logic [7:0] st);
        exp_q.push_back('{pulses: p, sa: sa, sb: sb, st: st});
    endtask

    // scores are sampled while the point pulse is high (pre-increment);
    // opp_steps is updated together with its pulse
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (point_a || point_b || opp_step)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, point_a, point_b, opp_step}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", {29'd0, point_a, point_b, opp_step}, {29'd0, e.pulses});
                chk("pulse_score_a", {28'd0, score_a}, {28'd0, e.sa});
                chk("pulse_score_b", {28'd0, score_b}, {28'd0, e.sb});
                chk("pulse_opp_steps", {24'd0, opp_steps}, {24'd0, e.st});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic m);
        mode_2p = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state", {29'd0, state}, 32'd1);
        chk("start_tgt_req", {31'd0, tgt_req}, 32'd1);
    endtask

    task automatic offer(input logic [7:0] t);
        tgt_in = t;
        tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
    endtask

    // accept t, then 4 matching PLAY cycles lead to AWARD
    task automatic round(input logic [7:0] t, input logic [7:0] a,
                         input logic [7:0] b);
        Ain = a;
        Bin = b;
        offer(t);
        chk("round_accept_state", {29'd0, state}, 32'd2);
        chk("round_target", {24'd0, target}, {24'd0, t});
        chk("round_tgt_req_low", {31'd0, tgt_req}, 32'd0);
        repeat (3) begin
            tick();
            chk("round_play_state", {29'd0, state}, 32'd2);
        end
        tick();
        chk("round_award_state", {29'd0, state}, 32'd3);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_outputs", {tgt_req, target, point_a, point_b, opp_step,
                            score_a, score_b, opp_steps, game_over, winner}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_without_start", {29'd0, state}, 32'd0);

        // game 1: two players
        start_game(1'b1);
        push(PA, 4'd0, 4'd0, 8'd0);
        round(8'h5A, 8'h5A, 8'h00);
        chk("r1_point_a", {31'd0, point_a}, 32'd1);
        tick();
        chk("r1_fetch", {29'd0, state}, 32'd1);
        chk("r1_tgt_req", {31'd0, tgt_req}, 32'd1);
        chk("r1_score_a", {28'd0, score_a}, 32'd1);

        // glitch: 3 matches, 1 miss, then 4 matches
        push(PA, 4'd1, 4'd0, 8'd0);
        Ain = 8'h00;
        Bin = 8'h00;
        offer(8'h33);
        Ain = 8'h33;
        repeat (3) tick();
        Ain = 8'h00;
        tick();
        Ain = 8'h33;
        repeat (3) tick();
        chk("glitch_no_early", {29'd0, state}, 32'd2);
        tick();
        chk("glitch_award", {29'd0, state}, 32'd3);
        tick();
        chk("glitch_score_a", {28'd0, score_a}, 32'd2);

        // repeated target refused, next accepted; B scores alone
        Ain = 8'h00;
        offer(8'h33);
        chk("reject_state", {29'd0, state}, 32'd1);
        chk("reject_tgt_req", {31'd0, tgt_req}, 32'd1);
        push(PB, 4'd2, 4'd0, 8'd0);
        round(8'h34, 8'h00, 8'h34);
        tick();
        chk("b_score", {28'd0, score_b}, 32'd1);

        // tie with tie_prio=0: A wins and reaches WIN_SCORE
        push(PA, 4'd2, 4'd1, 8'd0);
        round(8'h77, 8'h77, 8'h77);
        tick();
        chk("win_state", {29'd0, state}, 32'd4);
        chk("win_game_over", {31'd0, game_over}, 32'd1);
        chk("win_winner", {30'd0, winner}, 32'd1);
        chk("win_score_a", {28'd0, score_a}, 32'd3);

        // game 2: next tie favours B, then A
        start_game(1'b1);
        chk("restart_clear", {score_a, score_b, winner, game_over}, 32'd0);
        push(PB, 4'd0, 4'd0, 8'd0);
        round(8'h11, 8'h11, 8'h11);
        tick();
        push(PA, 4'd0, 4'd1, 8'd0);
        round(8'h22, 8'h22, 8'h22);
        tick();
        chk("tie_scores", {24'd0, score_a, score_b}, 32'h11);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_tgt_req", {31'd0, tgt_req}, 32'd0);
        chk("abort_hold", {16'd0, score_a, score_b, target}, 32'h1122);

        // game 3: opponent reaches OPP_LIMIT; Bin ignored in 1P
        start_game(1'b0);
        push(PO, 4'd0, 4'd0, 8'd1);
        push(PO, 4'd0, 4'd0, 8'd2);
        push(PO, 4'd0, 4'd0, 8'd3);
        Ain = 8'h00;
        Bin = 8'h44;
        offer(8'h44);
        repeat (5) tick();
        chk("opp_mid_state", {29'd0, state}, 32'd2);
        chk("opp_mid_steps", {24'd0, opp_steps}, 32'd2);
        tick();
        chk("opp_done", {29'd0, state}, 32'd4);
        chk("opp_winner", {30'd0, winner}, 32'd3);
        chk("opp_game_over", {31'd0, game_over}, 32'd1);
        chk("opp_steps_final", {24'd0, opp_steps}, 32'd3);

        // game 4: player qualifies on the 3rd wrap
        Bin = 8'h00;
        start_game(1'b0);
        chk("g4_steps_clear", {24'd0, opp_steps}, 32'd0);
        push(PO, 4'd0, 4'd0, 8'd1);
        push(PO, 4'd0, 4'd0, 8'd2);
        push(PA, 4'd0, 4'd0, 8'd2);
        offer(8'h55);
        repeat (2) tick();
        Ain = 8'h55;
        repeat (4) tick();
        chk("g4_award", {29'd0, state}, 32'd3);
        chk("g4_no_opp_step", {31'd0, opp_step}, 32'd0);
        chk("g4_steps_hold", {24'd0, opp_steps}, 32'd2);
        tick();
        chk("g4_score_a", {28'd0, score_a}, 32'd1);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored", {24'd0, 1'b0, state, score_a}, {24'd0, 1'b0, 3'd1, 4'd1});
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // game 5: async reset mid-PLAY with score_a=2
        start_game(1'b1);
        push(PA, 4'd0, 4'd0, 8'd0);
        round(8'h61, 8'h61, 8'h00);
        tick();
        push(PA, 4'd1, 4'd0, 8'd0);
        round(8'h62, 8'h62, 8'h00);
        tick();
        chk("g5_score_a", {28'd0, score_a}, 32'd2);
        Ain = 8'h00;
        offer(8'h63);
        chk("g5_play", {29'd0, state}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", {29'd0, state}, 32'd0);
        chk("async_rst_outputs", {tgt_req, target, point_a, point_b, opp_step,
                                  score_a, score_b, opp_steps, game_over, winner}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_idle", {29'd0, state}, 32'd0);
        start_game(1'b1);

        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/race_round_scheduler.md
Name: race_round_scheduler

Overview:
Round sequencer and answer arbiter for the binary racing game. It requests targets from the random-target source and holds the current target. It qualifies each player's switch answer against the target, arbitrates ties between players A and B, and paces the single-player opponent. It issues point/step pulses and scores to the renderer, replacing ad-hoc compare-on-every-clock logic in the game top.

Parameters:
WIN_SCORE, 3, points needed to win (1..15)
STABLE_CYC, 4, consecutive matching cycles before an answer qualifies (>=1)
OPP_DIV, 9, PLAY cycles per opponent step (>=1)
OPP_LIMIT, 80, opponent steps that end a 1P game as a loss (1..255)
REJECT_REPEAT, 1, if 1 a new target equal to the previous target is refused

Ports:
clk  in  1  game clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin/restart game
mode_2p  in  1  sampled on start: 1 = two players, 0 = player A vs opponent
abort  in  1  synchronous return to IDLE from any state
Ain  in  8  player A switches
Bin  in  8  player B switches
tgt_req  out  1  request new target
tgt_valid  in  1  tgt_in valid this cycle
tgt_in  in  8  candidate target
target  out  8  current target
point_a  out  1  one-cycle pulse: A scored
point_b  out  1  one-cycle pulse: B scored
opp_step  out  1  one-cycle pulse: opponent advanced
score_a  out  4  A score
score_b  out  4  B score
opp_steps  out  8  opponent progress
state  out  3  IDLE=0 FETCH=1 PLAY=2 AWARD=3 DONE=4
game_over  out  1  high in DONE
winner  out  2  00 none, 01 A, 10 B, 11 opponent

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; target 0; internal stab_a, stab_b, opp_cnt, tie_prio, mode register all 0. Everything is registered; no output is a combinational function of inputs.
- abort has priority over every transition except reset. Next cycle: IDLE, tgt_req 0, pulses 0. Scores and target hold.
- IDLE: start -> FETCH. Latch mode_2p; clear scores, opp_steps, winner.
- FETCH: tgt_req=1 from the first FETCH cycle.
  - Accept when tgt_valid=1 and not (REJECT_REPEAT and tgt_in==target): target<=tgt_in, tgt_req<=0, -> PLAY, clear stab_a/stab_b/opp_cnt.
  - Refused or absent tgt_valid: remain in FETCH with tgt_req high.
  - Latency start -> tgt_req high: 1 cycle.
- PLAY:
  - stab_x increments, saturating at STABLE_CYC-1, while Ax==target; clears on any mismatch cycle.
  - qual_x = (Ax==target) and (stab_x==STABLE_CYC-1). With STABLE_CYC=4, qualification occurs on the 4th consecutive matching cycle.
  - Bin is ignored when mode_2p=0.
  - Both qualify in the same cycle: the player with tie_prio wins (0=A, 1=B). tie_prio then flips to favour the loser.
  - Any qualification -> AWARD with the chosen player recorded.
  - 1P only: opp_cnt counts PLAY cycles 0..OPP_DIV-1 and wraps. On wrap: opp_step pulse, opp_steps+1.
    - If opp_steps+1==OPP_LIMIT: -> DONE, winner=11.
    - If the player qualifies in the same cycle, the player takes precedence; the opponent wrap that cycle is suppressed (no pulse, no increment).
  - opp_cnt holds (does not count) outside PLAY.
- AWARD (1 cycle): point_x pulse; score_x<=score_x+1.
  - New score==WIN_SCORE -> DONE, winner=01/10.
  - Otherwise -> FETCH; tgt_req asserts on the next cycle.
- DONE: game_over=1; winner, scores and target hold; start -> FETCH with scores cleared (same as IDLE start).
- start is ignored outside IDLE/DONE.
- Scores never exceed WIN_SCORE; opp_steps never exceeds OPP_LIMIT.

Test Plan:
- Reset mid-PLAY with score_a=2: rst_n low -> all outputs 0 and state 0 immediately, without waiting for a clk edge; after release, start is required to leave IDLE.
- 2P, start, tgt_in=0x5A with tgt_valid in the first FETCH cycle; Ain=0x5A held -> point_a pulses 5 cycles after accept (4 PLAY cycles + AWARD); score_a=1; tgt_req high the following cycle.
- Ain glitch: Ain=target for 3 cycles, 1 mismatch, 4 matches -> single point_a, only after the second run.
- Tie: Ain=Bin=target from the same cycle -> first tie point_b? No: first tie goes to A (tie_prio=0); the next tied round goes to B; score_a=1, score_b=1.
- REJECT_REPEAT: after target 0x33, offer tgt_in=0x33 then 0x34 -> first refused (tgt_req stays 1), 0x34 accepted.
- 1P with OPP_DIV=2, OPP_LIMIT=3 and no player input -> opp_step every 2nd PLAY cycle; on the 3rd step state=DONE, winner=11, game_over=1. Player qualifying on the same cycle as the 3rd wrap -> point_a, opp_steps stays 2.
